dct_block_loader: RTL

Input framing stage placed directly upstream of the 16-point CORDIC DCT. Accepts a serial stream of 20-bit samples over a valid/ready handshake, assembles each run of 16 consecutive samples into a block, and presents the block on 16 parallel registered outputs x0..x15. Each presented block is held stable for a programmable number of cycles so the CORDIC rotator pipeline sees constant operands. The fill buffer is double-buffered against the output register, so a steady stream sustains one block per 16 cycles when HOLD ≤ 16.

---
 rtl/dct_block_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dct_block_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dct_block_loader
//
// Input framing stage for the 16-point CORDIC DCT. Serial samples arrive on a
// valid/ready handshake and are collected into a 16-entry fill buffer. Once the
// buffer is full it is copied into the output register x0..x15, where it is
// held for HOLD cycles so the rotator pipeline sees constant operands. The fill
// buffer and the output register form a double buffer. A steady stream can
// therefore keep one block moving every 16 cycles whenever HOLD <= 16.
//
// Parameters
//   W     sample width (two's complement, passed through unmodified)
//   HOLD  cycles each block stays on x0..x15, legal range 1..255
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   in_data holds a sample
//   in_ready   loader can accept a sample this cycle (combinational)
//   in_data    sample
//   x0..x15    presented block, x0 = first sample of the block
//   blk_valid  x0..x15 hold a valid block
//   blk_start  one-cycle pulse in the first cycle of each presented block
//   blk_id     count of blocks presented, wraps 255 -> 0
// -----------------------------------------------------------------------------
module dct_block_loader #(
    parameter int W    = 20,
    parameter int HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] x0,
    output logic [W-1:0] x1,
    output logic [W-1:0] x2,
    output logic [W-1:0] x3,
    output logic [W-1:0] x4,
    output logic [W-1:0] x5,
    output logic [W-1:0] x6,
    output logic [W-1:0] x7,
    output logic [W-1:0] x8,
    output logic [W-1:0] x9,
    output logic [W-1:0] x10,
    output logic [W-1:0] x11,
    output logic [W-1:0] x12,
    output logic [W-1:0] x13,
    output logic [W-1:0] x14,
    output logic [W-1:0] x15,
    output logic         blk_valid,
    output logic         blk_start,
    output logic [7:0]   blk_id
);

    typedef enum logic {
        IDLE,
        HOLDING
    } state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    logic [W-1:0] fill_buf [16];
    logic [W-1:0] xr       [16];
    logic [3:0]   wp;
    logic         full;
    logic [7:0]   cnt;
    logic [7:0]   cnt_next;
    state_t       state;
    state_t       state_next;
    logic         blk_valid_next;
    logic         blk_start_next;
    logic [7:0]   blk_id_next;
    logic         can_load;
    logic         load;
    logic         accept;

    // The output register is free either when nothing is shown, or on the
    // last cycle of the current hold window.
    assign can_load = (state == IDLE) || ((state == HOLDING) && (cnt == 8'd0));
    assign load     = full & can_load;

    // A full buffer still accepts when it is being drained at this edge, so
    // a continuous stream is never stalled while HOLD <= 16.
    assign in_ready = rst & (~full | load);
    assign accept   = in_valid & in_ready;

    // NOTE: the fill buffer has no reset; wp and full decide which entries are
    // meaningful, so stale contents after reset are never presented.
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_buf[wp] <= in_data;
        end
    end

    // NOTE: non-blocking assignments let a sample land in fill_buf[0] at the
    // same edge where the old fill_buf[0] is copied into x0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp   <= 4'd0;
            full <= 1'b0;
        end else begin
            if (accept) begin
                wp <= wp + 4'd1;
            end
            // full only exists with wp back at 0, so an accept at a load edge
            // always targets entry 0 and the buffer ends up not full.
            if (accept && (wp == 4'd15)) begin
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

    // Output register: changes only at load edges, retains its value between
    // blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                xr[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                xr[i] <= fill_buf[i];
            end
        end
    end

    // Presenter FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            blk_valid <= 1'b0;
            blk_start <= 1'b0;
            blk_id    <= 8'd0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            blk_valid <= blk_valid_next;
            blk_start <= blk_start_next;
            blk_id    <= blk_id_next;
        end
    end

    // Presenter FSM: next state and registered outputs.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        blk_valid_next = blk_valid;
        blk_start_next = 1'b0;
        blk_id_next    = blk_id;

        if (load) begin
            state_next     = HOLDING;
            cnt_next       = HOLD_M1;
            blk_valid_next = 1'b1;
            blk_start_next = 1'b1;
            blk_id_next    = blk_id + 8'd1;
        end else if (state == HOLDING) begin
            if (cnt != 8'd0) begin
                cnt_next = cnt - 8'd1;
            end else if (!full) begin
                state_next     = IDLE;
                blk_valid_next = 1'b0;
            end
        end
    end

    assign x0  = xr[0];
    assign x1  = xr[1];
    assign x2  = xr[2];
    assign x3  = xr[3];
    assign x4  = xr[4];
    assign x5  = xr[5];
    assign x6  = xr[6];
    assign x7  = xr[7];
    assign x8  = xr[8];
    assign x9  = xr[9];
    assign x10 = xr[10];
    assign x11 = xr[11];
    assign x12 = xr[12];
    assign x13 = xr[13];
    assign x14 = xr[14];
    assign x15 = xr[15];

endmodule
